// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: IDLE/FETCH/ISSUE control with redirect squashing.
// Optional fetch watchdog is compiled in with `define FETCH_TIMEOUT_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic        halt_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [1:0]  redirect_kind_i,
    input  logic [31:0] redirect_target_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_data_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic [31:0] pc_o,
    output logic        busy_o,
    output logic        timeout_err_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        squash_q, squash_d;
    logic [31:0] squash_tgt_q, squash_tgt_d;

    logic        redir_hit;
    logic [31:0] redir_tgt;
    logic        tmo_fire;

    assign redir_hit = redirect_valid_i && (redirect_kind_i != 2'b11);
    assign redir_tgt = (redirect_kind_i == 2'b10) ? (instr_pc_q + redirect_target_i)
                                                  : redirect_target_i;

`ifdef FETCH_TIMEOUT_EN
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic        tmo_err_q, tmo_err_d;

    // Counts consecutive un-acked FETCH cycles; anything else restarts it.
    assign tmo_cnt_d = (state_q == S_FETCH && !imem_ack_i) ? tmo_cnt_q + 32'd1 : 32'd0;
    assign tmo_fire  = (state_q == S_FETCH) && !imem_ack_i && (tmo_cnt_q + 32'd1 == TIMEOUT);
    assign tmo_err_d = tmo_fire ? 1'b1 : (start_i ? 1'b0 : tmo_err_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= 32'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err_o = tmo_err_q;
`else
    assign tmo_fire      = 1'b0;
    assign timeout_err_o = 1'b0;

    // TIMEOUT only matters when the watchdog is compiled in.
    if (TIMEOUT == 0) begin : g_tmo_unused
    end
`endif

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        instr_pc_d   = instr_pc_q;
        valid_d      = valid_q;
        squash_d     = squash_q;
        squash_tgt_d = squash_tgt_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH: begin
                if (imem_ack_i) begin
                    if (squash_q || redir_hit) begin
                        // Returned word belongs to the abandoned path: drop it and re-fetch.
                        pc_d     = redir_hit ? redir_tgt : squash_tgt_q;
                        squash_d = 1'b0;
                    end else begin
                        instr_d    = imem_data_i;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd1;
                        valid_d    = 1'b1;
                        state_d    = S_ISSUE;
                    end
                end else if (tmo_fire) begin
                    squash_d = 1'b0;
                    state_d  = S_IDLE;
                end else if (redir_hit) begin
                    squash_d     = 1'b1;
                    squash_tgt_d = redir_tgt;
                end
            end
            S_ISSUE: begin
                if (redir_hit) begin
                    pc_d    = redir_tgt;
                    valid_d = 1'b0;
                    state_d = S_FETCH;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = halt_i ? S_IDLE : S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            instr_q      <= 32'd0;
            instr_pc_q   <= 32'd0;
            valid_q      <= 1'b0;
            squash_q     <= 1'b0;
            squash_tgt_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            instr_pc_q   <= instr_pc_d;
            valid_q      <= valid_d;
            squash_q     <= squash_d;
            squash_tgt_q <= squash_tgt_d;
        end
    end

    assign imem_req_o    = (state_q == S_FETCH);
    assign imem_addr_o   = pc_q;
    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign pc_o          = pc_q;
    assign busy_o        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed vectors, a behavioural model compared every cycle,
// and literal checkpoints. Define FETCH_TIMEOUT_EN to also exercise the watchdog.
module tb_fetch_sequencer;

    localparam int unsigned TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, halt, stall, rv, ack;
    logic [1:0]  rk;
    logic [31:0] rt, data;
    logic        imem_req, instr_valid, busy, timeout_err;
    logic [31:0] imem_addr, instr, instr_pc, pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .start_i(start), .halt_i(halt), .stall_i(stall),
        .redirect_valid_i(rv), .redirect_kind_i(rk), .redirect_target_i(rt),
        .imem_req_o(imem_req), .imem_addr_o(imem_addr),
        .imem_ack_i(ack), .imem_data_i(data),
        .instr_valid_o(instr_valid), .instr_o(instr), .instr_pc_o(instr_pc),
        .pc_o(pc), .busy_o(busy), .timeout_err_o(timeout_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: where the sequencer is, which word is on offer, and any pending redirect.
    int          m_mode = 0;  // 0 idle, 1 waiting for memory, 2 offering a word
    logic [31:0] m_pc = 0, m_instr = 0, m_ipc = 0, m_pend_tgt = 0;
    logic        m_offer = 0, m_pend = 0, m_err = 0;
    int          m_wait = 0;

    function automatic logic [31:0] dest(input logic [1:0] k, input logic [31:0] t,
                                         input logic [31:0] from);
        return (k == 2'b10) ? from + t : t;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = 0; m_pc = 0; m_instr = 0; m_ipc = 0;
            m_offer = 0; m_pend = 0; m_err = 0; m_wait = 0;
        end else begin
            automatic bit jump = rv && (rk != 2'b11);
            automatic logic [31:0] where = dest(rk, rt, m_ipc);
`ifdef FETCH_TIMEOUT_EN
            if (start) m_err = 0;
`endif
            if (m_mode == 0) begin
                if (start) begin m_mode = 1; m_wait = 0; end
            end else if (m_mode == 1) begin
                if (ack) begin
                    m_wait = 0;
                    if (jump) begin m_pc = where; m_pend = 0; end
                    else if (m_pend) begin m_pc = m_pend_tgt; m_pend = 0; end
                    else begin
                        m_instr = data; m_ipc = m_pc; m_pc = m_pc + 1;
                        m_offer = 1; m_mode = 2;
                    end
                end else begin
                    m_wait++;
`ifdef FETCH_TIMEOUT_EN
                    if (m_wait == TMO) begin
                        m_err = 1; m_mode = 0; m_pend = 0;
                    end else
`endif
                    if (jump) begin m_pend = 1; m_pend_tgt = where; end
                end
            end else begin
                if (jump) begin
                    m_pc = where; m_offer = 0; m_mode = 1; m_wait = 0;
                end else if (!stall) begin
                    m_offer = 0; m_mode = halt ? 0 : 1; m_wait = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", {31'd0, busy}, {31'd0, m_mode != 0});
        chk("imem_req", {31'd0, imem_req}, {31'd0, m_mode == 1});
        chk("pc", pc, m_pc);
        chk("imem_addr", imem_addr, m_pc);
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_offer});
        chk("instr", instr, m_instr);
        chk("instr_pc", instr_pc, m_ipc);
        chk("timeout_err", {31'd0, timeout_err}, {31'd0, m_err});
        if (instr_valid && !stall && !rst)
            $display("issue instr_pc=%h instr=%h", instr_pc, instr);
    end

    task automatic step(input logic s, input logic h, input logic st, input logic r,
                        input logic [1:0] k, input logic [31:0] t,
                        input logic a, input logic [31:0] d);
        start = s; halt = h; stall = st; rv = r; rk = k; rt = t; ack = a; data = d;
        @(posedge clk); #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
    endtask

    task automatic fetch_ack(input logic [31:0] d);
        step(0, 0, 0, 0, 2'b00, 32'd0, 1, d);
    endtask

    initial begin
        rst = 1'b1;
        start = 0; halt = 0; stall = 0; rv = 0; rk = 0; rt = 0; ack = 0; data = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("lit_reset_pc", pc, 32'h0);
        chk("lit_reset_busy", {31'd0, busy}, 32'd0);

        // Back-to-back fetches of A, B, C from addresses 0..2
        step(1, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        fetch_ack(32'hA);
        chk("lit_instr_a", instr, 32'hA);
        chk("lit_ipc_a", instr_pc, 32'h0);
        idle();
        fetch_ack(32'hB);
        chk("lit_ipc_b", instr_pc, 32'h1);
        idle();
        fetch_ack(32'hC);
        chk("lit_ipc_c", instr_pc, 32'h2);
        chk("lit_pc_3", pc, 32'h3);
        chk("lit_model_pc_3", m_pc, 32'h3);

        // Jump in ISSUE, then a backward branch relative to instr_pc 0x10
        step(0, 0, 0, 1, 2'b00, 32'h10, 0, 32'd0);
        fetch_ack(32'hD0);
        chk("lit_ipc_10", instr_pc, 32'h10);
        step(0, 0, 0, 1, 2'b10, 32'hFFFF_FFFE, 0, 32'd0);
        chk("lit_branch_addr", imem_addr, 32'h0E);
        chk("lit_branch_req", {31'd0, imem_req}, 32'd1);

        // Redirect coinciding with ack: data dropped, target loaded
        step(0, 0, 0, 1, 2'b00, 32'h5, 1, 32'hBAD0_BAD0);
        chk("lit_sim_pc", pc, 32'h5);
        chk("lit_sim_valid", {31'd0, instr_valid}, 32'd0);

        // Stall three cycles with instr_pc 5, consumed on the fourth
        fetch_ack(32'h55);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, 0, 2'b00, 32'd0, 0, 32'd0);
            chk("lit_stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("lit_stall_instr", instr, 32'h55);
        end
        idle();
        chk("lit_consumed", {31'd0, instr_valid}, 32'd0);

        // Jump during FETCH, ack two cycles later is squashed
        step(0, 0, 0, 1, 2'b00, 32'h40, 0, 32'd0);
        idle();
        fetch_ack(32'hDEAD);
        chk("lit_squash_addr", imem_addr, 32'h40);
        chk("lit_squash_valid", {31'd0, instr_valid}, 32'd0);

        // Overwritten pending redirect; kind 11 ignored
        step(0, 0, 0, 1, 2'b00, 32'h80, 0, 32'd0);
        step(0, 0, 0, 1, 2'b10, 32'h100, 0, 32'd0);
        step(0, 0, 0, 1, 2'b11, 32'h123, 0, 32'd0);
        fetch_ack(32'h1111);
        chk("lit_overwrite_pc", pc, 32'h105);
        fetch_ack(32'h77);
        step(0, 0, 1, 1, 2'b11, 32'h999, 0, 32'd0);
        chk("lit_kind3_pc", pc, 32'h106);
        chk("lit_kind3_valid", {31'd0, instr_valid}, 32'd1);

        // Wrap at the top of the address space, then halt
        step(0, 0, 0, 1, 2'b01, 32'hFFFF_FFFF, 0, 32'd0);
        fetch_ack(32'hEE);
        chk("lit_wrap_pc", pc, 32'h0);
        chk("lit_wrap_ipc", instr_pc, 32'hFFFF_FFFF);
        step(0, 1, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        chk("lit_halt_busy", {31'd0, busy}, 32'd0);

        // Controls ignored in IDLE
        step(0, 1, 1, 1, 2'b00, 32'h333, 1, 32'h5);
        chk("lit_idle_pc", pc, 32'h0);

        // Reset mid-FETCH; later ack ignored
        step(1, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        fetch_ack(32'h1234);
        chk("lit_rst_req", {31'd0, imem_req}, 32'd0);
        chk("lit_rst_instr", instr, 32'h0);

`ifdef FETCH_TIMEOUT_EN
        step(1, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        for (int i = 0; i < 3; i++) idle();
        chk("lit_tmo_pre", {31'd0, timeout_err}, 32'd0);
        idle();
        chk("lit_tmo_err", {31'd0, timeout_err}, 32'd1);
        chk("lit_tmo_req", {31'd0, imem_req}, 32'd0);
        step(1, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        chk("lit_tmo_clear", {31'd0, timeout_err}, 32'd0);
        fetch_ack(32'h42);
`else
        step(1, 0, 0, 0, 2'b00, 32'd0, 0, 32'd0);
        for (int i = 0; i < 20; i++) idle();
        chk("lit_wait_req", {31'd0, imem_req}, 32'd1);
        chk("lit_wait_err", {31'd0, timeout_err}, 32'd0);
        fetch_ack(32'h42);
        chk("lit_wait_instr", instr, 32'h42);
`endif
        idle();
        idle();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the word address loaded into pc on reset.
REQ-002 Parameter TIMEOUT, default 16, is the maximum number of FETCH cycles without imem_ack (used only with FETCH_TIMEOUT_EN).
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  begin fetching from the current pc.
REQ-006 halt  in  1  return to IDLE after the current instruction is consumed.
REQ-007 stall  in  1  decoder cannot accept instr this cycle.
REQ-008 redirect_valid  in  1  control-flow change request.
REQ-009 redirect_kind  in  2  encoding: 00 jump (absolute), 01 jr (absolute), 10 branch (instr_pc + target), 11 ignored.
REQ-010 redirect_target  in  32  absolute address or branch offset.
REQ-011 imem_req  out  1  instruction memory request.
REQ-012 imem_addr  out  32  request word address.
REQ-013 imem_ack  in  1  memory has returned imem_data.
REQ-014 imem_data  in  32  fetched instruction word.
REQ-015 instr_valid / instr / instr_pc  out  1/32/32  issued instruction and its address.
REQ-016 pc  out  32  address of the next fetch.
REQ-017 busy  out  1  high whenever the state is not IDLE.
REQ-018 timeout_err  out  1  sticky fetch-timeout flag.

Function
REQ-019 The FSM SHALL have states IDLE, FETCH and ISSUE; IDLE->FETCH on start, otherwise hold.
REQ-020 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, both held stable until imem_ack.
REQ-021 On imem_ack in FETCH: instr<=imem_data, instr_pc<=pc, pc<=pc+1 (32-bit wrap, FFFF_FFFF->0), instr_valid<=1, next state ISSUE; one cycle ack-to-valid latency.
REQ-022 In ISSUE with stall=1 and no redirect, instr, instr_pc and instr_valid SHALL hold unchanged.
REQ-023 In ISSUE with stall=0, the instruction is consumed at that edge: instr_valid<=0, next state FETCH, or IDLE if halt=1.
REQ-024 Redirect target SHALL be redirect_target for kinds 00/01 and instr_pc+redirect_target (mod 2^32) for kind 10; kind 11 SHALL have no effect.
REQ-025 Redirect in ISSUE SHALL take priority over stall: pc<=target, instr_valid<=0, next state FETCH.
REQ-026 Redirect in FETCH SHALL set a squash flag and latch the target; the outstanding request completes, its data is discarded (instr_valid stays 0), pc<=target, and FETCH re-issues.
REQ-027 A second redirect before the squashed ack SHALL overwrite the latched target.
REQ-028 Simultaneous redirect and imem_ack in FETCH SHALL discard imem_data and load the target.
REQ-029 redirect_valid, halt and stall SHALL be ignored in IDLE.

Reset
REQ-030 On rst: state IDLE; pc=RESET_PC; instr=0; instr_pc=0; instr_valid=0; imem_req=0; busy=0; timeout_err=0; squash flag cleared.
REQ-031 Reset mid-FETCH SHALL drop imem_req in the next cycle and ignore any later imem_ack until a new FETCH.

Configuration
REQ-032 With FETCH_TIMEOUT_EN defined, a counter SHALL count consecutive FETCH cycles without imem_ack; on reaching TIMEOUT, timeout_err<=1, imem_req<=0 and the FSM enters IDLE; timeout_err clears on rst or start.
REQ-033 Without FETCH_TIMEOUT_EN, no counter SHALL exist, timeout_err SHALL be constant 0, and FETCH SHALL wait indefinitely.

Verification
REQ-034 Reset, start, immediate ack of data 0xA, 0xB, 0xC -> instr_pc 0,1,2 issued on consecutive ISSUE cycles; pc=3.
REQ-035 ISSUE with instr_pc=5 and stall held 3 cycles -> instr and instr_valid stable for 3 cycles, consumed on the 4th.
REQ-036 Branch kind 10, offset 0xFFFF_FFFE, in ISSUE with instr_pc=0x10 -> next imem_addr=0x0E.
REQ-037 Jump to 0x40 in FETCH with ack 2 cycles later -> that data is not issued; next imem_addr=0x40.
REQ-038 pc=0xFFFF_FFFF with ack -> pc wraps to 0; halt with stall=0 -> IDLE and busy=0.
REQ-039 With FETCH_TIMEOUT_EN and TIMEOUT=4, no ack -> timeout_err=1 after 4 FETCH cycles and imem_req=0; a following start clears it.
